// File: rtl/enc_bundler.sv
// rtl/enc_bundler.sv - per-dimension popcount/threshold bundler producing a sparse hypervector.
// Optional macro ENC_BUNDLER_DENSITY_EN adds the hv_ones density counter output.
module enc_bundler #(
  parameter int HV_DIM         = 1024,
  parameter int FEATURE_COUNT  = 617,
  parameter int DIMS_PER_CYCLE = 32,
  localparam int CNT_W         = $clog2(FEATURE_COUNT + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [FEATURE_COUNT-1:0] bits_to_bundle_arr [HV_DIM],
  input  logic [CNT_W-1:0]         threshold,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [HV_DIM-1:0]        out_hv,
  output logic                     busy
`ifdef ENC_BUNDLER_DENSITY_EN
  ,
  output logic [$clog2(HV_DIM+1)-1:0] hv_ones
`endif
);

  localparam int NUM_SLICES = HV_DIM / DIMS_PER_CYCLE;
  localparam int SLICE_W    = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam int DIM_W      = (HV_DIM > 1) ? $clog2(HV_DIM) : 1;

  if (HV_DIM % DIMS_PER_CYCLE != 0) begin : g_dim_check
    $fatal(1, "enc_bundler: HV_DIM must be a multiple of DIMS_PER_CYCLE");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [SLICE_W-1:0]        r_slice_idx;
  logic [CNT_W-1:0]          r_thr;
  logic [HV_DIM-1:0]         r_out_hv;
  logic [DIM_W-1:0]          w_base;
  logic [DIMS_PER_CYCLE-1:0] w_lane_bits;
  logic                      w_last_slice;

  assign w_base       = DIM_W'(r_slice_idx) * DIM_W'(DIMS_PER_CYCLE);
  assign w_last_slice = (r_slice_idx == SLICE_W'(NUM_SLICES - 1));

  // One full-width popcount per lane; the array must be held stable by the producer during RUN.
  always_comb begin
    logic [CNT_W-1:0] v_cnt;
    logic [DIM_W-1:0] v_dim;
    w_lane_bits = '0;
    for (int l = 0; l < DIMS_PER_CYCLE; l++) begin
      v_dim = w_base + DIM_W'(l);
      v_cnt = '0;
      for (int f = 0; f < FEATURE_COUNT; f++) begin
        v_cnt = v_cnt + CNT_W'(bits_to_bundle_arr[v_dim][f]);
      end
      w_lane_bits[l] = (v_cnt >= r_thr);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)     w_state_nxt = S_RUN;
      S_RUN:   if (w_last_slice) w_state_nxt = S_DONE;
      S_DONE:  if (out_ready)    w_state_nxt = S_IDLE;
      default:                   w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
    busy      = (r_state == S_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slice_idx <= '0;
      r_thr       <= '0;
      r_out_hv    <= '0;
    end else begin
      if (r_state == S_IDLE && in_valid) begin
        r_thr       <= threshold;
        r_slice_idx <= '0;
      end
      if (r_state == S_RUN) begin
        r_out_hv[w_base +: DIMS_PER_CYCLE] <= w_lane_bits;
        if (!w_last_slice) r_slice_idx <= r_slice_idx + 1'b1;
      end
    end
  end

  assign out_hv = r_out_hv;

`ifdef ENC_BUNDLER_DENSITY_EN
  logic [$clog2(HV_DIM+1)-1:0] r_hv_ones;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hv_ones <= '0;
    end else if (r_state == S_IDLE && in_valid) begin
      r_hv_ones <= '0;
    end else if (r_state == S_RUN) begin
      r_hv_ones <= r_hv_ones + ($clog2(HV_DIM+1))'($countones(w_lane_bits));
    end
  end

  assign hv_ones = r_hv_ones;
`endif

endmodule
